// File: rtl/ap_program_counter.sv
// Program counter and fetch sequencer for the associative processor.
// Holds the fetch address stable per instruction; steps, jumps, enters/leaves the ISR.
module ap_program_counter #(
  parameter int ADDR_WIDTH_MEM = 16,
  parameter int OPCODE_WIDTH   = 4,
  parameter int ISA_WIDTH      = 30,
  parameter int INT_INS_DEPTH  = 27,
  parameter int START_ADDR     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ISA_WIDTH-1:0]      instruction,
  input  logic [OPCODE_WIDTH-1:0]   ins_valid,
  input  logic                      ap_done,
  input  logic                      int_req,
  output logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  output logic                      int_ack,
  output logic                      in_int,
  output logic                      halted,
  output logic                      pc_err
);

  localparam int AW  = ADDR_WIDTH_MEM;
  localparam int OPW = OPCODE_WIDTH;

  localparam logic [AW-1:0] START    = AW'(START_ADDR);
  localparam logic [AW-1:0] INT_BASE = {1'b1, {(AW-1){1'b0}}};
  localparam logic [AW-1:0] INT_ENTRY = INT_BASE + AW'(1);
  localparam logic [AW-1:0] INT_LAST = INT_BASE + AW'(INT_INS_DEPTH);

  localparam logic [OPW-1:0] OP_JMP  = OPW'(4'hD);
  localparam logic [OPW-1:0] OP_RTI  = OPW'(4'hE);
  localparam logic [OPW-1:0] OP_HALT = OPW'(4'hF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [AW-1:0]        ret_q, ret_d;
  logic [ISA_WIDTH-1:0] ir_q, ir_d;
  logic                 in_int_q, in_int_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;

  logic [OPW-1:0] op;
  logic [AW-1:0]  jmp_tgt;
  logic           is_jmp, is_rti, is_halt;
  logic           rti_ok, auto_ret, ret_clr, ovf;
  logic [AW-1:0]  nxt;

  assign op      = ir_q[ISA_WIDTH-1 -: OPW];
  assign jmp_tgt = ir_q[AW-1:0];
  assign is_jmp  = (op == OP_JMP);
  assign is_rti  = (op == OP_RTI);
  assign is_halt = (op == OP_HALT);

  // ISR falls back to the saved address after its last slot
  assign rti_ok   = is_rti & in_int_q;
  assign auto_ret = in_int_q & (addr_q == INT_LAST) & ~is_jmp & ~is_rti;
  assign ret_clr  = rti_ok | auto_ret;

  always_comb begin
    nxt = addr_q + AW'(1);
    unique case (1'b1)
      is_jmp:   nxt = jmp_tgt;
      rti_ok:   nxt = ret_q;
      auto_ret: nxt = ret_q;
      default:  ;
    endcase
  end

  assign ovf = ~in_int_q & (nxt >= INT_BASE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ret_d    = ret_q;
    ir_d     = ir_q;
    in_int_d = in_int_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        addr_d = START;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (&ins_valid) begin
          ir_d    = instruction;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ap_done) begin
          if (is_halt) begin
            state_d = S_HALT;
          end else if (ovf) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            if (int_req && !in_int_q) begin
              ret_d    = nxt;
              addr_d   = INT_ENTRY;
              in_int_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              addr_d = nxt;
              if (ret_clr) in_int_d = 1'b0;
            end
          end
        end
      end
      S_HALT: begin
        if (start) begin
          addr_d   = START;
          err_d    = 1'b0;
          in_int_d = 1'b0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= START;
      ret_q    <= '0;
      ir_q     <= '0;
      in_int_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ret_q    <= ret_d;
      ir_q     <= ir_d;
      in_int_q <= in_int_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  logic unused_ir;
  assign unused_ir = ^ir_q[ISA_WIDTH-OPW-1:AW];

  assign addr_ins = addr_q;
  assign int_ack  = ack_q;
  assign in_int   = in_int_q;
  assign halted   = (state_q == S_HALT);
  assign pc_err   = err_q;

endmodule

// File: tb/tb_ap_program_counter.sv
// Bench for ap_program_counter: scripted fetch/exec steps with a
// scoreboard of expected post-ap_done outputs.
module tb_ap_program_counter;

  localparam int AW  = 16;
  localparam int OPW = 4;
  localparam int ISA = 30;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [ISA-1:0] instruction;
  logic [OPW-1:0] ins_valid;
  logic           ap_done;
  logic           int_req;
  logic [AW-1:0]  addr_ins;
  logic           int_ack;
  logic           in_int;
  logic           halted;
  logic           pc_err;

  ap_program_counter dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instruction (instruction),
    .ins_valid   (ins_valid),
    .ap_done     (ap_done),
    .int_req     (int_req),
    .addr_ins    (addr_ins),
    .int_ack     (int_ack),
    .in_int      (in_int),
    .halted      (halted),
    .pc_err      (pc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          ack;
    logic          inint;
    logic          halt;
    logic          err;
    logic          use_addr;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] cur;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ISA-1:0] mk(input logic [3:0] op,
                                        input logic [AW-1:0] a);
    return {op, {(ISA-OPW-AW){1'b0}}, a};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " addr"}, 32'(addr_ins), 32'd1);
    chk({tag, " ack"}, 32'(int_ack), 32'd0);
    chk({tag, " inint"}, 32'(in_int), 32'd0);
    chk({tag, " halt"}, 32'(halted), 32'd0);
    chk({tag, " err"}, 32'(pc_err), 32'd0);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur = 16'd1;
    chk_reset(tag);
  endtask

  task automatic step(input string tag, input logic [3:0] op,
                      input logic [AW-1:0] a, input logic irq,
                      input logic [AW-1:0] ea, input logic eack,
                      input logic ei, input logic eh, input logic ee,
                      input logic ua);
    exp_t e;
    instruction = mk(op, a);
    ins_valid = '1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, " hold"}, 32'(addr_ins), 32'(cur));
    chk({tag, " ack_lo"}, 32'(int_ack), 32'd0);
    ins_valid = '0;
    ap_done = 1'b1;
    int_req = irq;
    sb.push_back('{ea, eack, ei, eh, ee, ua});
    @(negedge clk);
    ap_done = 1'b0;
    chk({tag, " sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.use_addr) chk({tag, " addr"}, 32'(addr_ins), 32'(e.addr));
      chk({tag, " ack"}, 32'(int_ack), 32'(e.ack));
      chk({tag, " inint"}, 32'(in_int), 32'(e.inint));
      chk({tag, " halt"}, 32'(halted), 32'(e.halt));
      chk({tag, " err"}, 32'(pc_err), 32'(e.err));
      if (e.use_addr) cur = e.addr;
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    ins_valid = '0;
    ap_done = 1'b0;
    int_req = 1'b0;
    instruction = '0;
    cur = 16'd1;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b1;
    @(negedge clk);
    do_start("start");

    step("seq1", 4'h1, 16'h0, 1'b0, 16'h2, 0, 0, 0, 0, 1);
    step("seq2", 4'h1, 16'h0, 1'b0, 16'h3, 0, 0, 0, 0, 1);
    step("seq3", 4'h1, 16'h0, 1'b0, 16'h4, 0, 0, 0, 0, 1);
    step("seq4", 4'h1, 16'h0, 1'b0, 16'h5, 0, 0, 0, 0, 1);
    step("jmp", 4'hD, 16'h0040, 1'b0, 16'h0040, 0, 0, 0, 0, 1);
    step("jmp7", 4'hD, 16'h0007, 1'b0, 16'h0007, 0, 0, 0, 0, 1);
    step("irq", 4'h1, 16'h0, 1'b1, 16'h8001, 1, 1, 0, 0, 1);
    step("isr1", 4'h1, 16'h0, 1'b0, 16'h8002, 0, 1, 0, 0, 1);
    step("isr2", 4'h1, 16'h0, 1'b0, 16'h8003, 0, 1, 0, 0, 1);
    step("rti", 4'hE, 16'h0, 1'b0, 16'h0008, 0, 0, 0, 0, 1);
    step("rti_nop", 4'hE, 16'h0, 1'b0, 16'h0009, 0, 0, 0, 0, 1);

    step("irq2", 4'h1, 16'h0, 1'b1, 16'h8001, 1, 1, 0, 0, 1);
    for (int a = 'h8001; a < 'h801B; a++)
      step("isr_loop", 4'h1, 16'h0, 1'b1, AW'(a + 1), 0, 1, 0, 0, 1);
    step("autoret", 4'h1, 16'h0, 1'b1, 16'h000A, 0, 0, 0, 0, 1);
    step("reenter", 4'h1, 16'h0, 1'b1, 16'h8001, 1, 1, 0, 0, 1);
    step("rti2", 4'hE, 16'h0, 1'b0, 16'h000B, 0, 0, 0, 0, 1);

    step("halt", 4'hF, 16'h0, 1'b1, 16'h000B, 0, 0, 1, 0, 1);
    int_req = 1'b0;
    do_start("restart");
    step("p1", 4'h1, 16'h0, 1'b0, 16'h0002, 0, 0, 0, 0, 1);
    step("jmpmax", 4'hD, 16'h7FFF, 1'b0, 16'h7FFF, 0, 0, 0, 0, 1);
    step("ovf", 4'h1, 16'h0, 1'b0, 16'h0000, 0, 0, 1, 1, 0);
    do_start("ovf_start");
    step("after", 4'h1, 16'h0, 1'b0, 16'h0002, 0, 0, 0, 0, 1);

    step("irq3", 4'h1, 16'h0, 1'b1, 16'h8001, 1, 1, 0, 0, 1);
    instruction = mk(4'h1, 16'h0);
    ins_valid = '1;
    @(negedge clk);
    ins_valid = '0;
    int_req = 1'b1;
    rst = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b1;
    int_req = 1'b0;
    @(negedge clk);
    do_start("post_start");
    step("post_rst", 4'h1, 16'h0, 1'b0, 16'h0002, 0, 0, 0, 0, 1);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
